// File: rtl/dsp_post_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : dsp_post_accumulator
// Brief   : Accumulates TAPS signed 36-bit products into 48 bits, then emits
//           the full sum and a rounded, saturated 18-bit result.
// Revision: 1.0  initial release
// ============================================================================
module dsp_post_accumulator #(
    parameter int TAPS  = 8,
    parameter int SHIFT = 4
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic signed [35:0] M,
    input  logic               M_VALID,
    output logic               M_READY,
    input  logic               OPSUB,
    input  logic               CLEAR,
    input  logic               OUT_READY,
    output logic               OUT_VALID,
    output logic        [47:0] P,
    output logic        [17:0] Y,
    output logic               SAT,
    output logic               OVF,
    output logic               BUSY
);

    localparam int CW = $clog2(TAPS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // Half-LSB rounding term; collapses to zero when SHIFT is 0.
    localparam logic signed [48:0] RND  = (49'sd1 <<< SHIFT) >>> 1;
    localparam logic signed [48:0] YMAX = 49'sd131071;
    localparam logic signed [48:0] YMIN = -49'sd131072;

    logic [1:0]          state_q, state_d;
    logic                busy_q;
    logic signed [47:0]  acc_q, acc_d;
    logic [CW-1:0]       count_q, count_d;
    logic [47:0]         p_q, p_d;
    logic [17:0]         y_q, y_d;
    logic                sat_q, sat_d;
    logic                ovf_q, ovf_d;
    logic                vld_q, vld_d;

    logic                accept;
    logic [CW-1:0]       count_inc;
    logic signed [47:0]  m_ext;
    logic signed [47:0]  sum;
    logic                step_ovf;
    logic signed [48:0]  rsum;
    logic signed [48:0]  r;
    logic                sat_hi;
    logic                sat_lo;

    assign accept    = M_VALID && M_READY;
    assign count_inc = count_q + CW'(1);
    assign m_ext     = {{12{M[35]}}, M};
    assign sum       = OPSUB ? (acc_q - m_ext) : (acc_q + m_ext);

    // Subtraction overflows when operand signs differ; addition when they match.
    assign step_ovf  = (OPSUB ? (acc_q[47] != m_ext[47]) : (acc_q[47] == m_ext[47]))
                       && (sum[47] != acc_q[47]);

    assign rsum   = $signed({acc_q[47], acc_q}) + RND;
    assign r      = rsum >>> SHIFT;
    assign sat_hi = r > YMAX;
    assign sat_lo = r < YMIN;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        if (CLEAR) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = (TAPS == 1) ? S_ROUND : S_ACCUM;
                S_ACCUM: if (accept && (count_inc == CW'(TAPS))) state_d = S_ROUND;
                S_ROUND: state_d = S_HOLD;
                S_HOLD:  if (OUT_READY) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        M_READY = RSTN && !CLEAR && ((state_q == S_IDLE) || (state_q == S_ACCUM));
    end

    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        p_d     = p_q;
        y_d     = y_q;
        sat_d   = sat_q;
        ovf_d   = ovf_q;
        vld_d   = vld_q;
        if (CLEAR) begin
            acc_d   = '0;
            count_d = '0;
            vld_d   = 1'b0;
            sat_d   = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    acc_d   = OPSUB ? -m_ext : m_ext;
                    count_d = CW'(1);
                    ovf_d   = 1'b0;
                end
                S_ACCUM: if (accept) begin
                    acc_d   = sum;
                    count_d = count_inc;
                    ovf_d   = ovf_q | step_ovf;
                end
                S_ROUND: begin
                    p_d   = acc_q;
                    y_d   = sat_hi ? 18'h1FFFF : (sat_lo ? 18'h20000 : r[17:0]);
                    sat_d = sat_hi | sat_lo;
                    vld_d = 1'b1;
                end
                S_HOLD: if (OUT_READY) vld_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            acc_q   <= '0;
            count_q <= '0;
            p_q     <= '0;
            y_q     <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            p_q     <= p_d;
            y_q     <= y_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
        end
    end

    assign OUT_VALID = vld_q;
    assign P         = p_q;
    assign Y         = y_q;
    assign SAT       = sat_q;
    assign OVF       = ovf_q;
    assign BUSY      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_post_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : tb_dsp_post_accumulator
// Brief   : Randomised self-checking bench with an arithmetic reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_dsp_post_accumulator;

    localparam int TAPS  = 4;
    localparam int SHIFT = 4;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [35:0] M = '0;
    logic        M_VALID = 1'b0;
    logic        OPSUB = 1'b0;
    logic        CLEAR = 1'b0;
    logic        OUT_READY = 1'b0;
    logic        M_READY;
    logic        OUT_VALID;
    logic [47:0] P;
    logic [17:0] Y;
    logic        SAT;
    logic        OVF;
    logic        BUSY;

    int total = 0;
    int bad   = 0;

    dsp_post_accumulator #(.TAPS(TAPS), .SHIFT(SHIFT)) dut (
        .CLK(CLK), .RSTN(RSTN), .M(M), .M_VALID(M_VALID), .M_READY(M_READY),
        .OPSUB(OPSUB), .CLEAR(CLEAR), .OUT_READY(OUT_READY), .OUT_VALID(OUT_VALID),
        .P(P), .Y(Y), .SAT(SAT), .OVF(OVF), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic longint wrap48(input longint x);
        return (x <<< 16) >>> 16;
    endfunction

    // Offer one product from a negedge and return just after the edge that takes it.
    task automatic push(input logic [35:0] v, input bit sub);
        int n;
        @(negedge CLK);
        M = v; OPSUB = sub; M_VALID = 1'b1;
        #1;
        n = 0;
        while (!M_READY && n < 20) begin
            @(negedge CLK); #1; n++;
        end
        if (!M_READY) begin
            chk("push_timeout", 64'(M_READY), 64'd1);
            M_VALID = 1'b0;
        end else begin
            @(posedge CLK);
        end
    endtask

    task automatic do_group(input logic [35:0] v[TAPS], input bit sub[TAPS],
                            input int hold, input bit early, input int gapmax);
        longint acc, ex, mv, r, y;
        bit ovf, sat;
        logic [47:0] pexp;
        logic [17:0] yexp;
        acc = 0; ovf = 0;
        for (int i = 0; i < TAPS; i++) begin
            mv = $signed(v[i]);
            ex = ((i == 0) ? 64'sd0 : acc) + (sub[i] ? -mv : mv);
            if (i > 0 && (ex > 64'sh7FFF_FFFF_FFFF || ex < -64'sh8000_0000_0000)) ovf = 1;
            acc = wrap48(ex);
        end
        r    = (acc + ((SHIFT > 0) ? (64'sd1 <<< (SHIFT - 1)) : 64'sd0)) >>> SHIFT;
        sat  = (r > 131071) || (r < -131072);
        y    = (r > 131071) ? 131071 : ((r < -131072) ? -131072 : r);
        pexp = acc[47:0];
        yexp = y[17:0];

        OUT_READY = early;
        for (int i = 0; i < TAPS; i++) begin
            int g;
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            repeat (g) begin
                @(negedge CLK); M_VALID = 1'b0;
            end
            push(v[i], sub[i]);
        end
        @(negedge CLK);
        M = 36'(64'({$urandom, $urandom}));
        M_VALID = 1'b1;
        chk("lat_k_valid", 64'(OUT_VALID), 64'd0);
        chk("round_busy", 64'(BUSY), 64'd1);
        chk("round_mready", 64'(M_READY), 64'd0);
        @(negedge CLK);
        chk("lat_k1_valid", 64'(OUT_VALID), 64'd1);
        chk("P", 64'(P), 64'(pexp));
        chk("Y", 64'(Y), 64'(yexp));
        chk("SAT", 64'(SAT), 64'(sat));
        chk("OVF", 64'(OVF), 64'(ovf));
        chk("hold_mready", 64'(M_READY), 64'd0);
        if (!early) begin
            repeat (hold) begin
                @(negedge CLK);
                chk("hold_valid", 64'(OUT_VALID), 64'd1);
                chk("hold_P", 64'(P), 64'(pexp));
                chk("hold_Y", 64'(Y), 64'(yexp));
                chk("hold_mready", 64'(M_READY), 64'd0);
            end
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        M_VALID = 1'b0; OUT_READY = 1'b0;
        chk("done_valid", 64'(OUT_VALID), 64'd0);
        chk("done_busy", 64'(BUSY), 64'd0);
        chk("done_P", 64'(P), 64'(pexp));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_P"}, 64'(P), 64'd0);
        chk({tag, "_Y"}, 64'(Y), 64'd0);
        chk({tag, "_SAT"}, 64'(SAT), 64'd0);
        chk({tag, "_OVF"}, 64'(OVF), 64'd0);
        chk({tag, "_BUSY"}, 64'(BUSY), 64'd0);
        chk({tag, "_VALID"}, 64'(OUT_VALID), 64'd0);
        chk({tag, "_MREADY"}, 64'(M_READY), 64'd0);
    endtask

    logic [35:0] va[TAPS];
    bit          sa[TAPS];

    initial begin
        logic [63:0] u;
        longint t;

        #1 chk_all_zero("reset");
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        #1 chk("post_reset_mready", 64'(M_READY), 64'd1);

        va = '{36'd16, 36'd32, 36'd48, 36'd64}; sa = '{0, 0, 0, 0};
        do_group(va, sa, 0, 1'b1, 0);

        va = '{36'd100, 36'd100, 36'd100, 36'd100}; sa = '{1, 1, 1, 1};
        do_group(va, sa, 0, 1'b1, 0);

        va = '{-36'sd6, -36'sd6, -36'sd6, -36'sd6}; sa = '{0, 0, 0, 0};
        do_group(va, sa, 1, 1'b0, 0);

        va = '{36'h4_0000_0000, 36'h4_0000_0000, 36'h4_0000_0000, 36'h4_0000_0000};
        sa = '{0, 0, 0, 0};
        do_group(va, sa, 0, 1'b1, 0);
        sa = '{1, 1, 1, 1};
        do_group(va, sa, 0, 1'b1, 0);

        va = '{36'd11, 36'd22, 36'd33, 36'd44}; sa = '{0, 1, 0, 0};
        do_group(va, sa, 5, 1'b0, 0);
        va = '{36'd7, 36'd9, 36'd13, 36'd1}; sa = '{0, 0, 0, 1};
        do_group(va, sa, 0, 1'b1, 0);

        push(36'd5, 1'b0);
        push(36'd7, 1'b0);
        @(negedge CLK);
        CLEAR = 1'b1; M_VALID = 1'b1;
        #1 chk("clear_mready", 64'(M_READY), 64'd0);
        @(negedge CLK);
        CLEAR = 1'b0; M_VALID = 1'b0;
        chk("clear_busy", 64'(BUSY), 64'd0);
        chk("clear_ovf", 64'(OVF), 64'd0);
        va = '{36'd1, 36'd1, 36'd1, 36'd1}; sa = '{0, 0, 0, 0};
        do_group(va, sa, 0, 1'b0, 0);

        for (int i = 0; i < TAPS; i++) push(36'h4_0000_0000, 1'b0);
        @(negedge CLK);
        M_VALID = 1'b0;
        @(negedge CLK);
        chk("hclr_valid_before", 64'(OUT_VALID), 64'd1);
        chk("hclr_sat_before", 64'(SAT), 64'd1);
        CLEAR = 1'b1; OUT_READY = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0; OUT_READY = 1'b0;
        chk("hclr_valid", 64'(OUT_VALID), 64'd0);
        chk("hclr_sat", 64'(SAT), 64'd0);
        chk("hclr_busy", 64'(BUSY), 64'd0);

        va = '{36'd3, 36'd4, 36'd5, 36'd6}; sa = '{0, 0, 0, 0};
        do_group(va, sa, 0, 1'b1, 0);
        for (int i = 0; i < 3; i++) push(36'd9, 1'b0);
        #2 RSTN = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge CLK);
        M_VALID = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        va = '{36'd2, 36'd2, 36'd2, 36'd2}; sa = '{0, 0, 0, 0};
        do_group(va, sa, 0, 1'b0, 0);

        for (int g = 0; g < 30; g++) begin
            for (int i = 0; i < TAPS; i++) begin
                case ($urandom_range(0, 2))
                    0: begin t = longint'($urandom_range(0, 2000)) - 1000; va[i] = t[35:0]; end
                    1: begin t = longint'($urandom_range(0, 1 << 20)) - (1 << 19); va[i] = t[35:0]; end
                    default: begin u = {$urandom, $urandom}; va[i] = u[35:0]; end
                endcase
                sa[i] = bit'($urandom_range(0, 1));
            end
            do_group(va, sa, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dsp_post_accumulator.md
# dsp_post_accumulator

Streaming post-multiply accumulator that sits directly downstream of the DSP slice's 36-bit multiplier output (M). It accepts a group of TAPS signed products over a valid/ready handshake and adds or subtracts each one into a 48-bit accumulator. It then produces the full-precision sum plus a rounded, saturated 18-bit result for the next filter stage. It provides FIR/dot-product accumulation with output backpressure.

## Interface
- TAPS, 8: products per accumulation group; legal range 1..1024.
- SHIFT, 4: arithmetic right shift applied before the 18-bit output; legal range 0..30.
- CLK  in  1  rising-edge clock.
- RSTN  in  1  asynchronous, active-low reset. Asserts immediately; deassertion is synchronised externally.
- M  in  36  signed product from the multiplier stage.
- M_VALID  in  1  M is valid this cycle.
- M_READY  out  1  block accepts M this cycle. Combinational from state; 0 while RSTN is low.
- OPSUB  in  1  sampled with each accepted product: 1 subtracts it, 0 adds it.
- CLEAR  in  1  synchronous abort of the current group.
- OUT_READY  in  1  consumer accepts the result.
- OUT_VALID  out  1  P, Y, SAT and OVF are valid.
- P  out  48  full accumulator result, two's complement.
- Y  out  18  rounded, saturated result.
- SAT  out  1  Y was clipped.
- OVF  out  1  sticky 48-bit signed overflow seen during the group.
- BUSY  out  1  state is not IDLE.

## Operation
- A product transfers on any rising edge where M_VALID and M_READY are both 1.
- M is sign-extended to 48 bits. The accumulator wraps modulo 2^48.
- OVF is set on any add/subtract whose operand signs produce a result of the wrong sign. It stays set until the next group starts.
- FSM states: IDLE, ACCUM, ROUND, HOLD.
- IDLE: M_READY=1. On a transfer, acc is loaded with ±M, count is set to 1, and OVF is cleared. Next state is ROUND if TAPS==1, otherwise ACCUM.
- ACCUM: M_READY=1. On each transfer, acc is updated to acc ± M and count increments. The transfer that makes count==TAPS moves the FSM to ROUND. With no transfer, the state holds and acc is unchanged.
- ROUND: one cycle, M_READY=0.
  - P is registered from acc.
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT, computed in 49 bits; no rounding term when SHIFT=0. Ties round toward +infinity.
  - Y is r clipped to [-131072, 131071]. SAT=1 if clipping occurred.
  - OUT_VALID is set. Next state is HOLD.
- HOLD: M_READY=0. P, Y, SAT, OVF and OUT_VALID are held stable until an edge with OUT_READY=1. On that edge OUT_VALID clears and the FSM returns to IDLE.
- CLEAR=1 at an edge, in any state, does the following:
  - state goes to IDLE; acc, count, OUT_VALID, SAT and OVF go to 0;
  - any pending result is discarded;
  - M_READY is 0 during a cycle with CLEAR=1, so no product is accepted that cycle.
- Reset value of every output: OUT_VALID=0, P=0, Y=0, SAT=0, OVF=0, BUSY=0, M_READY=0. Internal state is IDLE, acc=0, count=0.
- Reset mid-group: all outputs go to 0 immediately (asynchronously). The partial sum is lost.

## Timing
- Latency: if the last product of a group transfers at edge k, OUT_VALID is high after edge k+1, i.e. 1 cycle after the last accepted product.
- The earliest first product of the next group transfers at edge h+1, where h is the OUT_READY handshake edge.
- Best-case throughput: one group per TAPS+2 cycles.
- Gaps in M_VALID stall accumulation without corrupting it.
- OUT_READY may be high before OUT_VALID. Only an edge with both signals high completes the result handshake.
- All outputs except M_READY are registered.
- CLEAR and OUT_READY at the same edge: CLEAR wins, and the result is counted as discarded.

## Test plan
- Sum: TAPS=4, SHIFT=4, OPSUB=0, M=16,32,48,64 on back-to-back cycles, OUT_READY=1 → OUT_VALID high 1 cycle after the 4th accept, P=160, Y=10, SAT=0, OVF=0.
- Subtract and rounding tie: TAPS=4, SHIFT=0, OPSUB=1, M=100 ×4 → P=-400, Y=-400. Then SHIFT=4 with products summing to -24 → Y=-1.
- Saturation: TAPS=4, SHIFT=4, M=2^34 ×4 → P=2^36, Y=131071, SAT=1. The negated group → Y=-131072, SAT=1.
- Backpressure: hold OUT_READY low for 5 cycles with M_VALID held high → M_READY=0 and P/Y stable throughout. After the handshake, the next group sums correctly and no product is lost or duplicated.
- CLEAR mid-group: accept 2 products, assert CLEAR for one cycle, then feed 4 products of value 1 → P=4, OVF=0.
- Reset mid-group: drop RSTN after 3 accepts → all outputs 0 with no clock edge. After release, a fresh 4-product group of value 2 → P=8.
